rule_config: RTL

Control-plane rule writer for the header lookup stage. It accepts host rule commands over a valid/ready handshake and keeps a shadow copy of the six rule slots: four destination-MAC slots and two source-MAC slots. It serialises each change onto the one-cycle `ruleSet_valid`/`ruleSet` bus that the lookup stage consumes. It also supports replaying or clearing the whole table, so the lookup stage can be resynchronised after its own reset.

---
 rtl/rule_config.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/rule_config.sv
// rule_config: host rule writer keeping a six-slot shadow table and serialising changes onto ruleSet.
// Build option: define RULE_SEQ_TAG_EN to carry a wrapping 8-bit sequence tag in ruleSet[63:56].

module rule_config #(
    parameter int unsigned GAP   = 0,
    parameter int unsigned NSLOT = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [3:0]  cmd_slot,
    input  logic [51:0] cmd_data,
    output logic        ruleSet_valid,
    output logic [63:0] ruleSet,
    output logic        busy,
    output logic [7:0]  err_cnt
);

    localparam int unsigned RULE_W    = 52;
    localparam int unsigned SLOT_W    = 4;
    localparam int unsigned TAG_W     = 8;
    localparam int unsigned PTR_W     = 3;
    localparam int unsigned GAP_W     = 4;
    localparam int unsigned ERR_W     = 8;
    localparam int unsigned LAST_SLOT = NSLOT - 1;
    localparam logic        HAS_GAP   = (GAP != 0);

    localparam logic [1:0] OP_WRITE     = 2'b00;
    localparam logic [1:0] OP_CLEAR     = 2'b01;
    localparam logic [1:0] OP_REPLAY    = 2'b10;
    localparam logic [1:0] OP_CLEAR_ALL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EMIT  = 2'd1,
        S_SWEEP = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic               sweep_q;
    logic [GAP_W-1:0]   gap_q;
    logic [RULE_W-1:0]  shadow_q [NSLOT];
    logic [TAG_W-1:0]   tag_c;

`ifdef RULE_SEQ_TAG_EN
    logic [TAG_W-1:0]   tag_q;
`endif

    logic               accept_c;
    logic               single_c;
    logic               sweep_op_c;
    logic               slot_ok_c;
    logic               write_c;
    logic               bad_slot_c;
    logic               last_c;
    logic               load_c;
    logic [SLOT_W-1:0]  load_slot_c;
    logic [RULE_W-1:0]  load_rule_c;
    logic [RULE_W-1:0]  sweep_rule_c;

    // Commands are only taken in IDLE; reset masks the handshake.
    assign cmd_ready  = (state_q == S_IDLE) && !reset;
    assign accept_c   = cmd_valid && cmd_ready;
    assign single_c   = (cmd_op == OP_WRITE) || (cmd_op == OP_CLEAR);
    assign sweep_op_c = (cmd_op == OP_REPLAY) || (cmd_op == OP_CLEAR_ALL);
    assign slot_ok_c  = (cmd_slot <= SLOT_W'(LAST_SLOT));
    assign write_c    = accept_c && single_c && slot_ok_c;
    assign bad_slot_c = accept_c && single_c && !slot_ok_c;
    assign last_c     = (ptr_q == PTR_W'(LAST_SLOT));

`ifdef RULE_SEQ_TAG_EN
    assign tag_c = tag_q;
`else
    assign tag_c = '0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    if (single_c && slot_ok_c) begin
                        state_d = S_EMIT;
                    end else if (sweep_op_c) begin
                        state_d = S_SWEEP;
                    end
                end
            end
            S_EMIT: begin
                state_d = HAS_GAP ? S_WAIT : S_IDLE;
            end
            S_SWEEP: begin
                if (HAS_GAP) begin
                    state_d = S_WAIT;
                end else if (last_c) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SWEEP;
                end
            end
            S_WAIT: begin
                if (gap_q == '0) begin
                    state_d = sweep_q ? S_SWEEP : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output logic: the word for the next cycle is assembled here and registered below.
    always_comb begin
        ptr_d        = ptr_q;
        sweep_rule_c = '0;
        load_c       = 1'b0;
        load_slot_c  = '0;
        load_rule_c  = '0;

        if ((state_q == S_IDLE) && accept_c && sweep_op_c) begin
            ptr_d = '0;
        end else if (state_q == S_SWEEP) begin
            ptr_d = ptr_q + PTR_W'(1);
        end

        for (int unsigned i = 0; i < NSLOT; i++) begin
            if (ptr_d == PTR_W'(i)) begin
                sweep_rule_c = shadow_q[i];
            end
        end

        if (state_d == S_EMIT) begin
            load_c      = 1'b1;
            load_slot_c = cmd_slot;
            load_rule_c = (cmd_op == OP_WRITE) ? cmd_data : '0;
        end else if (state_d == S_SWEEP) begin
            load_c      = 1'b1;
            load_slot_c = SLOT_W'(ptr_d);
            // Clear-all zeroes the shadow on this same edge, so the first word must be zero too.
            load_rule_c = ((state_q == S_IDLE) && (cmd_op == OP_CLEAR_ALL)) ? '0 : sweep_rule_c;
        end
    end

    // Datapath: shadow table, sweep bookkeeping, gap timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q         <= '0;
            sweep_q       <= 1'b0;
            gap_q         <= '0;
            ruleSet_valid <= 1'b0;
            ruleSet       <= '0;
            busy          <= 1'b0;
            err_cnt       <= '0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            ptr_q         <= ptr_d;
            ruleSet_valid <= load_c;
            busy          <= (state_d != S_IDLE);

            if (load_c) begin
                ruleSet <= {tag_c, load_slot_c, load_rule_c};
            end

            if (accept_c && sweep_op_c) begin
                sweep_q <= 1'b1;
            end else if ((state_q == S_SWEEP) && last_c) begin
                sweep_q <= 1'b0;
            end

            if ((state_d == S_WAIT) && (state_q != S_WAIT)) begin
                gap_q <= GAP_W'(GAP - 1);
            end else if (state_q == S_WAIT) begin
                gap_q <= gap_q - GAP_W'(1);
            end

            if (bad_slot_c && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end

            for (int unsigned i = 0; i < NSLOT; i++) begin
                if (accept_c && (cmd_op == OP_CLEAR_ALL)) begin
                    shadow_q[i] <= '0;
                end else if (write_c && (cmd_slot == SLOT_W'(i))) begin
                    shadow_q[i] <= (cmd_op == OP_WRITE) ? cmd_data : '0;
                end
            end
        end
    end

`ifdef RULE_SEQ_TAG_EN
    // Sequence tag advances once per emitted word and wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag_q <= '0;
        end else if (load_c) begin
            tag_q <= tag_q + TAG_W'(1);
        end
    end
`endif

endmodule
